// File: rtl/mac4b_exec_unit.sv
// mac4b_exec_unit: 4-lane byte dot-product execution stage with credit-based result FIFO
// Optional perf counters (perf_ops_o, perf_stall_o) enabled by MAC4B_PERF_CNT_EN.
module mac4b_exec_unit #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [4:0]      issue_rd_i,
  input  logic [1:0]      issue_funct3_i,
  input  logic [31:0]     rs1_i,
  input  logic [31:0]     rs2_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [4:0]      result_rd_o,
  output logic [31:0]     result_data_o,
  output logic            result_we_o
`ifdef MAC4B_PERF_CNT_EN
  ,
  output logic [31:0]     perf_ops_o,
  output logic [31:0]     perf_stall_o
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ID_W + 37;
  logic                 accept, push, pop;
  logic [CW:0]          credit;
  logic                 s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]      s1_id_q, s1_id_d, s2_id_q, s2_id_d;
  logic [4:0]           s1_rd_q, s1_rd_d, s2_rd_q, s2_rd_d;
  logic [3:0][17:0]     s1_p_q, s1_p_d;
  logic [31:0]          s2_sum_q, s2_sum_d;
  logic [EW-1:0]        mem_q [DEPTH];
  logic [EW-1:0]        mem_d [DEPTH];
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  // Credit counts every op that will land in the FIFO, so stages never stall
  always_comb begin
    credit         = (CW+1)'(count_q) + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
    issue_ready_o  = !flush_i && credit < (CW+1)'(DEPTH);
    accept         = issue_valid_i && issue_ready_o;
    result_valid_o = count_q != '0;
    result_we_o    = result_valid_o;
    {result_id_o, result_rd_o, result_data_o} = mem_q[rptr_q];
    pop            = result_valid_o && result_ready_i;
    push           = s2_valid_q && !flush_i;
  end
  // Stage 1 multiplies extended bytes; stage 2 sums sign-extended products
  always_comb begin
    s1_valid_d = accept;
    s1_id_d    = accept ? issue_id_i : s1_id_q;
    s1_rd_d    = accept ? issue_rd_i : s1_rd_q;
    s1_p_d     = s1_p_q;
    for (int i = 0; i < 4; i++)
      if (accept)
        s1_p_d[i] = {{10{issue_funct3_i[0] & rs1_i[8*i+7]}}, rs1_i[8*i +: 8]} *
                    {{10{issue_funct3_i[1] & rs2_i[8*i+7]}}, rs2_i[8*i +: 8]};
    s2_valid_d = s1_valid_q && !flush_i;
    s2_id_d    = s1_id_q;
    s2_rd_d    = s1_rd_q;
    s2_sum_d   = '0;
    for (int i = 0; i < 4; i++)
      s2_sum_d = s2_sum_d + {{14{s1_p_q[i][17]}}, s1_p_q[i]};
  end
  // Result FIFO bookkeeping; flush empties it after any coincident pop
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = {s2_id_q, s2_rd_q, s2_sum_q};
    wptr_d  = flush_i ? '0 : wptr_q + PW'(push);
    rptr_d  = flush_i ? '0 : rptr_q + PW'(pop);
    count_d = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_rd_q    <= '0;
      s1_p_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_rd_q    <= '0;
      s2_sum_q   <= '0;
      mem_q      <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_rd_q    <= s1_rd_d;
      s1_p_q     <= s1_p_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_rd_q    <= s2_rd_d;
      s2_sum_q   <= s2_sum_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end
  assert property (@(posedge clk_i) disable iff (rst_i) !(push && count_q == CW'(DEPTH)));
`ifdef MAC4B_PERF_CNT_EN
  logic [31:0] perf_ops_q, perf_ops_d, perf_stall_q, perf_stall_d;
  // Free-running event counters, immune to flush
  always_comb begin
    perf_ops_d   = perf_ops_q + 32'(pop);
    perf_stall_d = perf_stall_q + 32'(issue_valid_i && !issue_ready_o);
  end
  // Counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end
  assign perf_ops_o   = perf_ops_q;
  assign perf_stall_o = perf_stall_q;
`endif
endmodule

// File: tb/tb_mac4b_exec_unit.sv
// tb_mac4b_exec_unit: vector table, corner sequences and randomized model check
module tb_mac4b_exec_unit;
  logic        clk = 1'b0, rst, flush, iv, ir, rv, rr, rwe;
  logic [2:0]  iid, rid;
  logic [4:0]  ird, rrd;
  logic [1:0]  f3;
  logic [31:0] rs1, rs2, rdat;
`ifdef MAC4B_PERF_CNT_EN
  logic [31:0] pops, pstall;
`endif
  int passed = 0, total = 0;
  typedef struct {
    logic [31:0] rs1, rs2;
    logic [1:0]  f3;
    logic [2:0]  id;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;
  typedef struct {
    logic [2:0]  id;
    logic [4:0]  rd;
    logic [31:0] d;
    int          age;
  } ent_t;
  vec_t        vt [9];
  ent_t        fq [$];
  ent_t        inf [$];
  ent_t        nq [$];
  logic [31:0] bexp [4];
  logic [31:0] sexp [8];
  int          acc, exp_ops, exp_stall;
  logic        er, pop_m;

  always #5 clk = ~clk;

  mac4b_exec_unit dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(iv), .issue_ready_o(ir), .issue_id_i(iid), .issue_rd_i(ird),
    .issue_funct3_i(f3), .rs1_i(rs1), .rs2_i(rs2),
    .result_valid_o(rv), .result_ready_i(rr), .result_id_o(rid), .result_rd_o(rrd),
    .result_data_o(rdat), .result_we_o(rwe)
`ifdef MAC4B_PERF_CNT_EN
    , .perf_ops_o(pops), .perf_stall_o(pstall)
`endif
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    int x, y, s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      x = int'(a[8*i +: 8]);
      y = int'(b[8*i +: 8]);
      if (f[0] && x > 127) x -= 256;
      if (f[1] && y > 127) y -= 256;
      s += x * y;
    end
    return 32'(s);
  endfunction

  initial begin
    vt[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 3'd1, 5'd5,  32'h0003F804};
    vt[1] = '{32'h80808080, 32'h7F7F7F7F, 2'b11, 3'd2, 5'd6,  32'hFFFF0200};
    vt[2] = '{32'h80808080, 32'h7F7F7F7F, 2'b01, 3'd3, 5'd7,  32'hFFFF0200};
    vt[3] = '{32'h80808080, 32'h7F7F7F7F, 2'b10, 3'd4, 5'd8,  32'h0000FE00};
    vt[4] = '{32'h01020304, 32'h05060708, 2'b00, 3'd5, 5'd9,  32'h00000046};
    vt[5] = '{32'hFF00FF00, 32'h01010101, 2'b01, 3'd6, 5'd10, 32'hFFFFFFFE};
    vt[6] = '{32'h80808080, 32'h80808080, 2'b11, 3'd7, 5'd31, 32'h00010000};
    vt[7] = '{32'hFFFFFFFF, 32'h80808080, 2'b01, 3'd0, 5'd1,  32'hFFFFFE00};
    vt[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 3'd2, 5'd3,  32'h00000004};
    rst = 1'b1; flush = 1'b0; iv = 1'b0; rr = 1'b0;
    iid = '0; ird = '0; f3 = '0; rs1 = '0; rs2 = '0;
    #12;
    chk("rst_ready", 32'(ir), 32'd1);
    chk("rst_valid", 32'(rv), 32'd0);
    chk("rst_we", 32'(rwe), 32'd0);
    chk("rst_id", 32'(rid), 32'd0);
    chk("rst_rd", 32'(rrd), 32'd0);
    chk("rst_data", rdat, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    // single-op vectors with latency check
    rr = 1'b1;
    for (int v = 0; v < 9; v++) begin
      rs1 = vt[v].rs1; rs2 = vt[v].rs2; f3 = vt[v].f3; iid = vt[v].id; ird = vt[v].rd;
      iv = 1'b1;
      #1;
      chk("tbl_ready", 32'(ir), 32'd1);
      tick();
      iv = 1'b0;
      chk("tbl_lat_n1", 32'(rv), 32'd0);
      tick();
      chk("tbl_lat_n2", 32'(rv), 32'd0);
      tick();
      chk("tbl_valid", 32'(rv), 32'd1);
      chk("tbl_we", 32'(rwe), 32'd1);
      chk("tbl_data", rdat, vt[v].exp);
      chk("tbl_id", 32'(rid), 32'(vt[v].id));
      chk("tbl_rd", 32'(rrd), 32'(vt[v].rd));
      tick();
      chk("tbl_popped", 32'(rv), 32'd0);
    end
    // backpressure: credits stop accepts at DEPTH
    rr = 1'b0; iv = 1'b1; acc = 0;
    for (int k = 0; k < 8; k++) begin
      iid = 3'(k); ird = 5'(k); rs1 = $urandom; rs2 = $urandom; f3 = 2'($urandom);
      #1;
      if (ir) begin
        if (acc < 4) bexp[acc] = dot(rs1, rs2, f3);
        acc++;
      end
      tick();
    end
    iv = 1'b0;
    #1;
    chk("bp_accepts", 32'(acc), 32'd4);
    chk("bp_ready_low", 32'(ir), 32'd0);
    for (int s = 0; s < 3; s++) begin
      chk("bp_stable_data", rdat, bexp[0]);
      chk("bp_stable_id", 32'(rid), 32'd0);
      tick();
    end
    rr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_pop_valid", 32'(rv), 32'd1);
      chk("bp_pop_id", 32'(rid), 32'(k));
      chk("bp_pop_data", rdat, bexp[k]);
      tick();
    end
    chk("bp_drained", 32'(rv), 32'd0);
    chk("bp_ready_back", 32'(ir), 32'd1);
    // streaming: one result per cycle, first two edges after first accept
    for (int t = 0; t < 12; t++) begin
      if (t < 8) begin
        iv = 1'b1; iid = 3'(t); ird = 5'(t); rs1 = $urandom; rs2 = $urandom; f3 = 2'($urandom);
        sexp[t] = dot(rs1, rs2, f3);
      end else iv = 1'b0;
      #1;
      if (t < 8) chk("st_ready", 32'(ir), 32'd1);
      tick();
      if (t >= 2 && t <= 9) begin
        chk("st_valid", 32'(rv), 32'd1);
        chk("st_id", 32'(rid), 32'(t - 2));
        chk("st_data", rdat, sexp[t-2]);
      end else chk("st_idle", 32'(rv), 32'd0);
    end
    // flush with three ops in flight and a coincident issue
    rr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1; iid = 3'(k); rs1 = $urandom; rs2 = $urandom;
      tick();
    end
    flush = 1'b1; iid = 3'd3;
    #1;
    chk("fl_ready_low", 32'(ir), 32'd0);
    tick();
    flush = 1'b0; iv = 1'b0;
    #1;
    chk("fl_ready_next", 32'(ir), 32'd1);
    rr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("fl_no_result", 32'(rv), 32'd0);
      tick();
    end
    // asynchronous reset with two results buffered
    rr = 1'b0; iv = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iid = 3'(k); rs1 = $urandom | 32'h01010101; rs2 = 32'h01010101; f3 = 2'b00;
      tick();
    end
    iv = 1'b0;
    tick();
    tick();
    chk("rs_buffered", 32'(rv), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_valid_drop", 32'(rv), 32'd0);
    chk("rs_ready", 32'(ir), 32'd1);
    chk("rs_data", rdat, 32'd0);
`ifdef MAC4B_PERF_CNT_EN
    chk("rs_perf_ops", pops, 32'd0);
    chk("rs_perf_stall", pstall, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();
    // randomized traffic against a queue-level model
    exp_ops = 0; exp_stall = 0;
    for (int c = 0; c < 400; c++) begin
      iv = $urandom_range(3) != 0;
      rr = $urandom_range(2) != 0;
      flush = $urandom_range(24) == 0;
      iid = 3'(c); ird = 5'($urandom); f3 = 2'($urandom);
      rs1 = $urandom; rs2 = $urandom;
      #1;
      er = !flush && (fq.size() + inf.size()) < 4;
      chk("rnd_ready", 32'(ir), 32'(er));
      chk("rnd_valid", 32'(rv), 32'(fq.size() != 0));
      chk("rnd_we", 32'(rwe), 32'(fq.size() != 0));
      if (fq.size() != 0) begin
        chk("rnd_id", 32'(rid), 32'(fq[0].id));
        chk("rnd_rd", 32'(rrd), 32'(fq[0].rd));
        chk("rnd_data", rdat, fq[0].d);
      end
      pop_m = fq.size() != 0 && rr;
      if (pop_m) exp_ops++;
      if (iv && !er) exp_stall++;
      if (flush) begin
        fq.delete();
        inf.delete();
      end else begin
        if (pop_m) void'(fq.pop_front());
        nq.delete();
        foreach (inf[j]) begin
          if (inf[j].age == 1) fq.push_back(inf[j]);
          else begin
            nq.push_back(inf[j]);
            nq[nq.size()-1].age++;
          end
        end
        inf = nq;
        if (iv && er) inf.push_back('{id: iid, rd: ird, d: dot(rs1, rs2, f3), age: 0});
      end
      tick();
    end
    iv = 1'b0; flush = 1'b0;
`ifdef MAC4B_PERF_CNT_EN
    chk("perf_ops", pops, 32'(exp_ops));
    chk("perf_stall", pstall, 32'(exp_stall));
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
